// File: rtl/branch_stack_if.sv
// Bundle of dispatch-side allocation and branch-resolution signals for branch_stack.
// The master side is dispatch plus the branch FU; the slave side is branch_stack itself.
`ifndef B_MASK_WIDTH
`define B_MASK_WIDTH 4
`endif

interface branch_stack_if #(
    parameter int N_BR   = `B_MASK_WIDTH,
    parameter int CKPT_W = 64
);
    logic              alloc_req;
    logic [CKPT_W-1:0] alloc_ckpt;
    logic              alloc_gnt;
    logic [N_BR-1:0]   alloc_b_id;
    logic [N_BR-1:0]   cur_b_mask;
    logic              full;
    logic [1:0]        br_task;
    logic [N_BR-1:0]   br_b_id;
    logic [1:0]        rem_br_task;
    logic [N_BR-1:0]   rem_b_id;
    logic [CKPT_W-1:0] restore_ckpt;

    modport master (
        output alloc_req, alloc_ckpt, br_task, br_b_id,
        input  alloc_gnt, alloc_b_id, cur_b_mask, full,
               rem_br_task, rem_b_id, restore_ckpt
    );

    modport slave (
        input  alloc_req, alloc_ckpt, br_task, br_b_id,
        output alloc_gnt, alloc_b_id, cur_b_mask, full,
               rem_br_task, rem_b_id, restore_ckpt
    );
endinterface

// File: rtl/branch_stack.sv
// Branch checkpoint and mask manager: hands out one-hot branch IDs at dispatch,
// keeps a recovery checkpoint and a parent mask per live branch, and turns
// CLEAR/SQUASH reports from the branch FU into broadcasts and ID releases.
// br_task encoding: 0 = NOTHING, 1 = CLEAR, 2 = SQUASH (3 is never legal).
`ifndef B_MASK_WIDTH
`define B_MASK_WIDTH 4
`endif

module branch_stack #(
    parameter int N_BR   = `B_MASK_WIDTH,
    parameter int CKPT_W = 64
) (
    input  logic           clock,
    input  logic           reset,
    branch_stack_if.slave  bs
);
    localparam logic [1:0] TASK_NOTHING = 2'd0;
    localparam logic [1:0] TASK_CLEAR   = 2'd1;
    localparam logic [1:0] TASK_SQUASH  = 2'd2;

    logic [N_BR-1:0]             valid_q,  valid_d;
    logic [N_BR-1:0][N_BR-1:0]   parent_q, parent_d;
    logic [N_BR-1:0][CKPT_W-1:0] ckpt_q,   ckpt_d;

    logic            id_onehot;
    logic            legal;
    logic            is_clear;
    logic            is_squash;
    logic [N_BR-1:0] free_vec;
    logic [N_BR-1:0] free_onehot;
    logic [N_BR-1:0] live_mask;
    logic            gnt;
    logic [N_BR-1:0] kill;

    // Decode the resolution, pick the lowest free entry and drive all outputs.
    always_comb begin
        id_onehot   = (bs.br_b_id != '0) && ((bs.br_b_id & (bs.br_b_id - N_BR'(1))) == '0);
        legal       = ((bs.br_task == TASK_CLEAR) || (bs.br_task == TASK_SQUASH))
                      && id_onehot && ((bs.br_b_id & valid_q) != '0);
        is_clear    = legal && (bs.br_task == TASK_CLEAR);
        is_squash   = legal && (bs.br_task == TASK_SQUASH);
        free_vec    = ~valid_q;
        free_onehot = free_vec & (~free_vec + N_BR'(1));
        live_mask   = valid_q & ~(is_clear ? bs.br_b_id : '0);
        gnt         = bs.alloc_req && !(&valid_q) && !is_squash;

        bs.full         = &valid_q;
        bs.cur_b_mask   = live_mask;
        bs.alloc_gnt    = gnt;
        bs.alloc_b_id   = gnt ? free_onehot : '0;
        bs.rem_br_task  = legal ? bs.br_task : TASK_NOTHING;
        bs.rem_b_id     = legal ? bs.br_b_id : '0;
        bs.restore_ckpt = '0;
        for (int i = 0; i < N_BR; i++) begin
            if (is_squash && bs.br_b_id[i]) begin
                bs.restore_ckpt = bs.restore_ckpt | ckpt_q[i];
            end
        end
    end

    // Next entry state: clear or squash releases first, then the new allocation.
    always_comb begin
        valid_d  = valid_q;
        parent_d = parent_q;
        ckpt_d   = ckpt_q;
        kill     = '0;
        if (is_clear) begin
            valid_d = valid_d & ~bs.br_b_id;
            for (int i = 0; i < N_BR; i++) begin
                parent_d[i] = parent_q[i] & ~bs.br_b_id;
            end
        end
        if (is_squash) begin
            for (int i = 0; i < N_BR; i++) begin
                kill[i] = bs.br_b_id[i] || ((parent_q[i] & bs.br_b_id) != '0);
            end
            valid_d = valid_d & ~kill;
        end
        if (gnt) begin
            for (int i = 0; i < N_BR; i++) begin
                if (free_onehot[i]) begin
                    valid_d[i]  = 1'b1;
                    parent_d[i] = live_mask;
                    ckpt_d[i]   = bs.alloc_ckpt;
                end
            end
        end
    end

    // Entry registers; reset wins over any same-cycle allocation or resolution.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q  <= '0;
            parent_q <= '0;
            ckpt_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            parent_q <= parent_d;
            ckpt_q   <= ckpt_d;
        end
    end
endmodule

// File: tb/tb_branch_stack.sv
// Self-checking bench for branch_stack. Each step drives inputs on a falling
// edge, pushes the expected outputs to a queue, and samples the DUT shortly
// after; each scenario task then drains and compares the queues itself.
module tb_branch_stack;
    localparam logic [1:0] T_NOTHING = 2'd0;
    localparam logic [1:0] T_CLEAR   = 2'd1;
    localparam logic [1:0] T_SQUASH  = 2'd2;

    typedef struct packed {
        logic        gnt;
        logic [3:0]  bid;
        logic [3:0]  cur;
        logic        full;
        logic [1:0]  rtask;
        logic [3:0]  rem;
        logic [63:0] ckpt;
    } out_t;

    logic clock;
    logic reset;
    int   checks;
    int   failures;
    out_t exp_q[$];
    out_t obs_q[$];

    branch_stack_if #(.N_BR(4), .CKPT_W(64)) bus ();

    branch_stack #(.N_BR(4), .CKPT_W(64)) dut (
        .clock (clock),
        .reset (reset),
        .bs    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic out_t mk(input logic g, input logic [3:0] b, input logic [3:0] c,
                                input logic f, input logic [1:0] t, input logic [3:0] r,
                                input logic [63:0] k);
        out_t o;
        o.gnt = g; o.bid = b; o.cur = c; o.full = f; o.rtask = t; o.rem = r; o.ckpt = k;
        return o;
    endfunction

    function automatic out_t sample_outputs();
        out_t o;
        o.gnt   = bus.alloc_gnt;
        o.bid   = bus.alloc_b_id;
        o.cur   = bus.cur_b_mask;
        o.full  = bus.full;
        o.rtask = bus.rem_br_task;
        o.rem   = bus.rem_b_id;
        o.ckpt  = bus.restore_ckpt;
        return o;
    endfunction

    task automatic step(input logic req, input logic [63:0] ck, input logic [1:0] t,
                        input logic [3:0] bid, input out_t exp);
        bus.alloc_req  = req;
        bus.alloc_ckpt = ck;
        bus.br_task    = t;
        bus.br_b_id    = bid;
        exp_q.push_back(exp);
        #2;
        obs_q.push_back(sample_outputs());
        @(negedge clock);
    endtask

    task automatic apply_reset();
        bus.alloc_req  = 1'b0;
        bus.alloc_ckpt = '0;
        bus.br_task    = T_NOTHING;
        bus.br_b_id    = '0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic fill_four();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 64'hA0 + 64'(k), T_NOTHING, 4'b0000,
                 mk(1'b1, 4'(1 << k), 4'((1 << k) - 1), 1'b0, T_NOTHING, 4'b0000, 64'h0));
        end
    endtask

    task automatic test_reset();
        out_t e, o;
        int   idx;
        apply_reset();
        step(1'b0, 64'h0, T_NOTHING, 4'b0000, mk(0, 4'b0000, 4'b0000, 0, T_NOTHING, 4'b0000, 64'h0));
        fill_four();
        reset = 1'b1;
        bus.alloc_req = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        step(1'b0, 64'h0, T_NOTHING, 4'b0000, mk(0, 4'b0000, 4'b0000, 0, T_NOTHING, 4'b0000, 64'h0));
        step(1'b1, 64'h77, T_NOTHING, 4'b0000, mk(1, 4'b0001, 4'b0000, 0, T_NOTHING, 4'b0000, 64'h0));
        idx = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL reset[%0d] got gnt=%b bid=%b cur=%b full=%b task=%0d rem=%b ckpt=%h, want gnt=%b bid=%b cur=%b full=%b task=%0d rem=%b ckpt=%h",
                         idx, o.gnt, o.bid, o.cur, o.full, o.rtask, o.rem, o.ckpt,
                         e.gnt, e.bid, e.cur, e.full, e.rtask, e.rem, e.ckpt);
            end
            idx++;
        end
    endtask

    task automatic test_alloc_fill();
        out_t e, o;
        int   idx;
        apply_reset();
        fill_four();
        step(1'b1, 64'hA4, T_NOTHING, 4'b0000, mk(0, 4'b0000, 4'b1111, 1, T_NOTHING, 4'b0000, 64'h0));
        idx = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL alloc_fill[%0d] got gnt=%b bid=%b cur=%b full=%b task=%0d rem=%b ckpt=%h, want gnt=%b bid=%b cur=%b full=%b task=%0d rem=%b ckpt=%h",
                         idx, o.gnt, o.bid, o.cur, o.full, o.rtask, o.rem, o.ckpt,
                         e.gnt, e.bid, e.cur, e.full, e.rtask, e.rem, e.ckpt);
            end
            idx++;
        end
    endtask

    task automatic test_clear();
        out_t e, o;
        int   idx;
        apply_reset();
        fill_four();
        step(1'b0, 64'h0, T_CLEAR, 4'b0010, mk(0, 4'b0000, 4'b1101, 1, T_CLEAR, 4'b0010, 64'h0));
        step(1'b1, 64'hB0, T_NOTHING, 4'b0000, mk(1, 4'b0010, 4'b1101, 0, T_NOTHING, 4'b0000, 64'h0));
        // The reused 0010 must carry parent 1101, so squashing 0100 also frees it.
        step(1'b0, 64'h0, T_SQUASH, 4'b0100, mk(0, 4'b0000, 4'b1111, 1, T_SQUASH, 4'b0100, 64'hA2));
        step(1'b0, 64'h0, T_NOTHING, 4'b0000, mk(0, 4'b0000, 4'b0001, 0, T_NOTHING, 4'b0000, 64'h0));
        idx = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL clear[%0d] got gnt=%b bid=%b cur=%b full=%b task=%0d rem=%b ckpt=%h, want gnt=%b bid=%b cur=%b full=%b task=%0d rem=%b ckpt=%h",
                         idx, o.gnt, o.bid, o.cur, o.full, o.rtask, o.rem, o.ckpt,
                         e.gnt, e.bid, e.cur, e.full, e.rtask, e.rem, e.ckpt);
            end
            idx++;
        end
    endtask

    task automatic test_squash();
        out_t e, o;
        int   idx;
        apply_reset();
        fill_four();
        step(1'b0, 64'h0, T_SQUASH, 4'b0010, mk(0, 4'b0000, 4'b1111, 1, T_SQUASH, 4'b0010, 64'hA1));
        step(1'b0, 64'h0, T_NOTHING, 4'b0000, mk(0, 4'b0000, 4'b0001, 0, T_NOTHING, 4'b0000, 64'h0));
        step(1'b1, 64'hC0, T_NOTHING, 4'b0000, mk(1, 4'b0010, 4'b0001, 0, T_NOTHING, 4'b0000, 64'h0));
        step(1'b1, 64'hC1, T_NOTHING, 4'b0000, mk(1, 4'b0100, 4'b0011, 0, T_NOTHING, 4'b0000, 64'h0));
        step(1'b0, 64'h0, T_SQUASH, 4'b0100, mk(0, 4'b0000, 4'b0111, 0, T_SQUASH, 4'b0100, 64'hC1));
        idx = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL squash[%0d] got gnt=%b bid=%b cur=%b full=%b task=%0d rem=%b ckpt=%h, want gnt=%b bid=%b cur=%b full=%b task=%0d rem=%b ckpt=%h",
                         idx, o.gnt, o.bid, o.cur, o.full, o.rtask, o.rem, o.ckpt,
                         e.gnt, e.bid, e.cur, e.full, e.rtask, e.rem, e.ckpt);
            end
            idx++;
        end
    endtask

    task automatic test_alloc_with_clear();
        out_t e, o;
        int   idx;
        apply_reset();
        step(1'b1, 64'hA0, T_NOTHING, 4'b0000, mk(1, 4'b0001, 4'b0000, 0, T_NOTHING, 4'b0000, 64'h0));
        step(1'b1, 64'hA1, T_NOTHING, 4'b0000, mk(1, 4'b0010, 4'b0001, 0, T_NOTHING, 4'b0000, 64'h0));
        step(1'b1, 64'hD0, T_CLEAR, 4'b0001, mk(1, 4'b0100, 4'b0010, 0, T_CLEAR, 4'b0001, 64'h0));
        step(1'b0, 64'h0, T_NOTHING, 4'b0000, mk(0, 4'b0000, 4'b0110, 0, T_NOTHING, 4'b0000, 64'h0));
        // New entry's parent is 0010, so squashing 0010 takes it down too.
        step(1'b0, 64'h0, T_SQUASH, 4'b0010, mk(0, 4'b0000, 4'b0110, 0, T_SQUASH, 4'b0010, 64'hA1));
        step(1'b0, 64'h0, T_NOTHING, 4'b0000, mk(0, 4'b0000, 4'b0000, 0, T_NOTHING, 4'b0000, 64'h0));
        idx = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL alloc_clear[%0d] got gnt=%b bid=%b cur=%b full=%b task=%0d rem=%b ckpt=%h, want gnt=%b bid=%b cur=%b full=%b task=%0d rem=%b ckpt=%h",
                         idx, o.gnt, o.bid, o.cur, o.full, o.rtask, o.rem, o.ckpt,
                         e.gnt, e.bid, e.cur, e.full, e.rtask, e.rem, e.ckpt);
            end
            idx++;
        end
    endtask

    task automatic test_alloc_with_squash();
        out_t e, o;
        int   idx;
        apply_reset();
        step(1'b1, 64'hA0, T_NOTHING, 4'b0000, mk(1, 4'b0001, 4'b0000, 0, T_NOTHING, 4'b0000, 64'h0));
        step(1'b1, 64'hE0, T_SQUASH, 4'b0001, mk(0, 4'b0000, 4'b0001, 0, T_SQUASH, 4'b0001, 64'hA0));
        step(1'b0, 64'h0, T_NOTHING, 4'b0000, mk(0, 4'b0000, 4'b0000, 0, T_NOTHING, 4'b0000, 64'h0));
        step(1'b1, 64'hF0, T_NOTHING, 4'b0000, mk(1, 4'b0001, 4'b0000, 0, T_NOTHING, 4'b0000, 64'h0));
        step(1'b0, 64'h0, T_SQUASH, 4'b0001, mk(0, 4'b0000, 4'b0001, 0, T_SQUASH, 4'b0001, 64'hF0));
        idx = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL alloc_squash[%0d] got gnt=%b bid=%b cur=%b full=%b task=%0d rem=%b ckpt=%h, want gnt=%b bid=%b cur=%b full=%b task=%0d rem=%b ckpt=%h",
                         idx, o.gnt, o.bid, o.cur, o.full, o.rtask, o.rem, o.ckpt,
                         e.gnt, e.bid, e.cur, e.full, e.rtask, e.rem, e.ckpt);
            end
            idx++;
        end
    endtask

    task automatic test_illegal();
        out_t e, o;
        int   idx;
        apply_reset();
        step(1'b1, 64'hA0, T_NOTHING, 4'b0000, mk(1, 4'b0001, 4'b0000, 0, T_NOTHING, 4'b0000, 64'h0));
        step(1'b0, 64'h0, T_SQUASH, 4'b0100, mk(0, 4'b0000, 4'b0001, 0, T_NOTHING, 4'b0000, 64'h0));
        step(1'b0, 64'h0, T_CLEAR, 4'b0011, mk(0, 4'b0000, 4'b0001, 0, T_NOTHING, 4'b0000, 64'h0));
        step(1'b0, 64'h0, T_NOTHING, 4'b0000, mk(0, 4'b0000, 4'b0001, 0, T_NOTHING, 4'b0000, 64'h0));
        // An ignored squash must not block a same-cycle allocation.
        step(1'b1, 64'h55, T_SQUASH, 4'b1000, mk(1, 4'b0010, 4'b0001, 0, T_NOTHING, 4'b0000, 64'h0));
        step(1'b0, 64'h0, T_NOTHING, 4'b0000, mk(0, 4'b0000, 4'b0011, 0, T_NOTHING, 4'b0000, 64'h0));
        idx = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL illegal[%0d] got gnt=%b bid=%b cur=%b full=%b task=%0d rem=%b ckpt=%h, want gnt=%b bid=%b cur=%b full=%b task=%0d rem=%b ckpt=%h",
                         idx, o.gnt, o.bid, o.cur, o.full, o.rtask, o.rem, o.ckpt,
                         e.gnt, e.bid, e.cur, e.full, e.rtask, e.rem, e.ckpt);
            end
            idx++;
        end
    endtask

    task automatic test_back_to_back();
        out_t e, o;
        int   idx;
        apply_reset();
        fill_four();
        step(1'b1, 64'hD1, T_CLEAR, 4'b0001, mk(0, 4'b0000, 4'b1110, 1, T_CLEAR, 4'b0001, 64'h0));
        step(1'b1, 64'hD2, T_NOTHING, 4'b0000, mk(1, 4'b0001, 4'b1110, 0, T_NOTHING, 4'b0000, 64'h0));
        step(1'b0, 64'h0, T_SQUASH, 4'b0001, mk(0, 4'b0000, 4'b1111, 1, T_SQUASH, 4'b0001, 64'hD2));
        idx = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL back_to_back[%0d] got gnt=%b bid=%b cur=%b full=%b task=%0d rem=%b ckpt=%h, want gnt=%b bid=%b cur=%b full=%b task=%0d rem=%b ckpt=%h",
                         idx, o.gnt, o.bid, o.cur, o.full, o.rtask, o.rem, o.ckpt,
                         e.gnt, e.bid, e.cur, e.full, e.rtask, e.rem, e.ckpt);
            end
            idx++;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.alloc_req  = 1'b0;
        bus.alloc_ckpt = '0;
        bus.br_task    = T_NOTHING;
        bus.br_b_id    = '0;
        @(negedge clock);
        test_reset();
        test_alloc_fill();
        test_clear();
        test_squash();
        test_alloc_with_clear();
        test_alloc_with_squash();
        test_illegal();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
